// File: rtl/sbqm_pkg.sv
// sbqm_pkg: shared widths, constants, FSM states and wait-time numerator helper for the SBqM queue controller
package sbqm_pkg;
    localparam int PCOUNT_W = 3;
    localparam int TCOUNT_W = 2;
    localparam int SVC_TIME = 3;
    localparam int WTIME_W  = 5;
    localparam logic [PCOUNT_W-1:0] PCOUNT_MAX = '1;
    typedef enum logic [1:0] {IDLE, LOAD, DIV, DONE} state_t;
    function automatic logic [WTIME_W-1:0] wt_num(input logic [PCOUNT_W-1:0] p, input logic [TCOUNT_W-1:0] t);
        return (p == '0) ? '0 : WTIME_W'(SVC_TIME * (int'(p) + int'(t) - 1));
    endfunction
endpackage

// File: rtl/sbqm_wtime_div.sv
// sbqm_wtime_div: serial restoring divider, one quotient bit per cycle, operands latched on i_start
module sbqm_wtime_div
    import sbqm_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_start,
    input  logic [WTIME_W-1:0]  i_num,
    input  logic [TCOUNT_W-1:0] i_den,
    output logic [WTIME_W-1:0]  o_quo,
    output logic                o_done
);
    localparam int CNT_W = $clog2(WTIME_W + 1);
    logic [WTIME_W-1:0]  r_quo;
    logic [TCOUNT_W-1:0] r_rem, r_den;
    logic [CNT_W-1:0]    r_cnt;
    logic [TCOUNT_W:0]   w_sh, w_diff;
    logic                w_ge;
    // remainder stays below the divisor, so it fits in TCOUNT_W bits
    assign w_sh   = {r_rem, r_quo[WTIME_W-1]};
    assign w_ge   = w_sh >= {1'b0, r_den};
    assign w_diff = w_sh - {1'b0, r_den};
    assign o_quo  = r_quo;
    assign o_done = r_cnt == CNT_W'(1);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_quo <= '0;
            r_rem <= '0;
            r_den <= '0;
            r_cnt <= '0;
        end else if (i_start) begin
            r_quo <= i_num;
            r_den <= i_den;
            r_rem <= '0;
            r_cnt <= CNT_W'(WTIME_W);
        end else if (r_cnt != '0) begin
            r_quo <= {r_quo[WTIME_W-2:0], w_ge};
            r_rem <= w_ge ? w_diff[TCOUNT_W-1:0] : w_sh[TCOUNT_W-1:0];
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end
endmodule

// File: rtl/sbqm_queue_ctrl.sv
// sbqm_queue_ctrl: sensor-driven bounded customer count with serial wait-time computation
// QUEUE_ALARM_EN adds an alarm pulse on rejected arrivals/departures
module sbqm_queue_ctrl
    import sbqm_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                front_sensor,
    input  logic                back_sensor,
    input  logic [TCOUNT_W-1:0] tcount,
    output logic [PCOUNT_W-1:0] pcount,
    output logic                full,
    output logic                empty,
    output logic [WTIME_W-1:0]  wtime,
    output logic                wtime_valid,
    output logic                busy
`ifdef QUEUE_ALARM_EN
    ,
    output logic                alarm
`endif
);
    logic [1:0]          r_fs, r_bs;
    logic                r_fs_d, r_bs_d, r_full, r_empty, r_wtime_valid;
    logic                w_arr, w_dep, w_up, w_dn, w_pending, w_div_done;
    logic [PCOUNT_W-1:0] r_pcount, r_lat_p, w_pcount_nx;
    logic [TCOUNT_W-1:0] r_lat_t, w_teff;
    logic [WTIME_W-1:0]  r_wtime, w_quo;
    state_t              r_state, w_state_nx;
    assign w_arr       = r_fs[1] & ~r_fs_d;
    assign w_dep       = r_bs[1] & ~r_bs_d;
    // a simultaneous departure frees the slot at full, but is ignored at empty
    assign w_up        = w_arr & ~r_full & (~w_dep | r_empty);
    assign w_dn        = w_dep & ~w_arr & ~r_empty;
    assign w_pcount_nx = r_pcount + PCOUNT_W'(w_up) - PCOUNT_W'(w_dn);
    assign w_teff      = (tcount == '0) ? TCOUNT_W'(1) : tcount;
    assign w_pending   = (r_pcount != r_lat_p) || (w_teff != r_lat_t);
    assign pcount      = r_pcount;
    assign full        = r_full;
    assign empty       = r_empty;
    assign wtime       = r_wtime;
    assign wtime_valid = r_wtime_valid;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fs     <= '0;
            r_bs     <= '0;
            r_fs_d   <= 1'b0;
            r_bs_d   <= 1'b0;
            r_pcount <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            r_fs     <= {r_fs[0], front_sensor};
            r_bs     <= {r_bs[0], back_sensor};
            r_fs_d   <= r_fs[1];
            r_bs_d   <= r_bs[1];
            r_pcount <= w_pcount_nx;
            r_full   <= w_pcount_nx == PCOUNT_MAX;
            r_empty  <= w_pcount_nx == '0;
        end
    end
    // reset latch matches the reset count and a single teller so no spurious computation follows reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_lat_p       <= '0;
            r_lat_t       <= TCOUNT_W'(1);
            r_wtime       <= '0;
            r_wtime_valid <= 1'b0;
        end else begin
            r_state       <= w_state_nx;
            r_wtime_valid <= r_state == DONE;
            if (r_state == LOAD) begin
                r_lat_p <= r_pcount;
                r_lat_t <= w_teff;
            end
            if (r_state == DONE) r_wtime <= w_quo;
        end
    end
    always_comb begin
        w_state_nx = r_state;
        busy       = r_state != IDLE;
        case (r_state)
            IDLE:    w_state_nx = w_pending ? LOAD : IDLE;
            LOAD:    w_state_nx = DIV;
            DIV:     w_state_nx = w_div_done ? DONE : DIV;
            default: w_state_nx = IDLE;
        endcase
    end
    sbqm_wtime_div u_div (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_start (r_state == LOAD),
        .i_num   (wt_num(r_pcount, w_teff)),
        .i_den   (w_teff),
        .o_quo   (w_quo),
        .o_done  (w_div_done)
    );
`ifdef QUEUE_ALARM_EN
    logic r_alarm;
    assign alarm = r_alarm;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_alarm <= 1'b0;
        else        r_alarm <= (w_arr & ~w_dep & r_full) | (w_dep & ~w_arr & r_empty);
    end
`endif
endmodule

// File: tb/tb_sbqm_queue_ctrl.sv
// tb_sbqm_queue_ctrl: scoreboard bench for sbqm_queue_ctrl; alarm checks follow QUEUE_ALARM_EN
module tb_sbqm_queue_ctrl;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       front_sensor = 1'b0;
    logic       back_sensor = 1'b0;
    logic [1:0] tcount = 2'd1;
    logic [2:0] pcount;
    logic       full, empty, wtime_valid, busy;
    logic [4:0] wtime;
`ifdef QUEUE_ALARM_EN
    logic       alarm;
`endif
    typedef struct {int wt; int cy;} exp_t;
    exp_t sb[$];
    int   errors = 0, checks = 0, cyc = 0, n_valid = 0, n_alarm = 0, ea = 0, mp = 0, mt = 1;

    sbqm_queue_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .front_sensor (front_sensor),
        .back_sensor  (back_sensor),
        .tcount       (tcount),
        .pcount       (pcount),
        .full         (full),
        .empty        (empty),
        .wtime        (wtime),
        .wtime_valid  (wtime_valid),
        .busy         (busy)
`ifdef QUEUE_ALARM_EN
        ,
        .alarm        (alarm)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic int exp_wt(input int p, input int t);
        int te = (t == 0) ? 1 : t;
        return (p == 0) ? 0 : (3 * (p + te - 1)) / te;
    endfunction

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (wtime_valid) begin
                n_valid++;
                if (sb.size() == 0) check("unexpected_valid", 1, 0);
                else begin
                    e = sb.pop_front();
                    check("wtime", int'(wtime), e.wt);
                    if (e.cy != 0) check("latency", cyc, e.cy);
                end
            end
`ifdef QUEUE_ALARM_EN
            if (alarm) n_alarm++;
`endif
        end
    end

    task automatic wait_idle();
        int n = 0;
        while ((sb.size() != 0 || busy) && n < 60) begin
            @(negedge clk);
            n++;
        end
        check("idle_timeout", int'(sb.size() != 0 || busy), 0);
    endtask

    task automatic stim(input bit a, input bit d);
        int np = mp;
        @(negedge clk);
        front_sensor = a;
        back_sensor  = d;
        if (a && d) np = (mp == 0) ? 1 : mp;
        else if (a) begin
            if (mp == 7) ea++;
            else np = mp + 1;
        end else if (d) begin
            if (mp == 0) ea++;
            else np = mp - 1;
        end
        if (np != mp) sb.push_back('{exp_wt(np, mt), cyc + 11});
        mp = np;
        repeat (4) @(negedge clk);
        front_sensor = 1'b0;
        back_sensor  = 1'b0;
        repeat (4) @(negedge clk);
        wait_idle();
    endtask

    task automatic set_t(input int t);
        int ot = (mt == 0) ? 1 : mt;
        int nt = (t == 0) ? 1 : t;
        @(negedge clk);
        tcount = 2'(t);
        mt = t;
        if (nt != ot) sb.push_back('{exp_wt(mp, t), 0});
        wait_idle();
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_pcount"}, int'(pcount), 0);
        check({tag, "_empty"}, int'(empty), 1);
        check({tag, "_full"}, int'(full), 0);
        check({tag, "_wtime"}, int'(wtime), 0);
        check({tag, "_valid"}, int'(wtime_valid), 0);
        check({tag, "_busy"}, int'(busy), 0);
`ifdef QUEUE_ALARM_EN
        check({tag, "_alarm"}, int'(alarm), 0);
`endif
    endtask

    initial begin
        int snap;
        repeat (3) @(negedge clk);
        check_reset_state("rst");
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) stim(1'b1, 1'b0);
        check("p3_pcount", int'(pcount), 3);
        check("p3_empty", int'(empty), 0);
        check("p3_wtime", int'(wtime), 9);
        // reset during the division aborts it silently
        @(negedge clk);
        front_sensor = 1'b1;
        repeat (5) @(negedge clk);
        check("mid_busy", int'(busy), 1);
        rst_n = 1'b0;
        front_sensor = 1'b0;
        #1;
        check_reset_state("midrst");
        mp = 0;
        snap = n_valid;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("no_valid_after_rst", n_valid, snap);
        check("post_rst_pcount", int'(pcount), 0);
        set_t(3);
        for (int i = 0; i < 8; i++) stim(1'b1, 1'b0);
        check("full_pcount", int'(pcount), 7);
        check("full_flag", int'(full), 1);
        check("full_wtime", int'(wtime), 9);
        stim(1'b1, 1'b1);
        check("both_at_full", int'(pcount), 7);
        set_t(2);
        for (int i = 0; i < 3; i++) stim(1'b0, 1'b1);
        check("t2_p4_wtime", int'(wtime), 7);
        for (int i = 0; i < 2; i++) stim(1'b0, 1'b1);
        set_t(0);
        check("t0_p2_pcount", int'(pcount), 2);
        check("t0_p2_wtime", int'(wtime), 6);
        for (int i = 0; i < 2; i++) stim(1'b0, 1'b1);
        stim(1'b0, 1'b1);
        check("dep_at_empty_pcount", int'(pcount), 0);
        check("dep_at_empty_flag", int'(empty), 1);
        stim(1'b1, 1'b1);
        check("both_at_empty", int'(pcount), 1);
        // second arrival lands while the first result is still dividing
        @(negedge clk);
        snap = n_valid;
        sb.push_back('{exp_wt(mp + 1, mt), cyc + 11});
        sb.push_back('{exp_wt(mp + 2, mt), 0});
        mp = mp + 2;
        front_sensor = 1'b1;
        @(negedge clk);
        front_sensor = 1'b0;
        @(negedge clk);
        front_sensor = 1'b1;
        repeat (4) @(negedge clk);
        front_sensor = 1'b0;
        repeat (4) @(negedge clk);
        wait_idle();
        check("b2b_valids", n_valid - snap, 2);
        check("b2b_pcount", int'(pcount), 3);
        check("b2b_wtime", int'(wtime), 9);
        check("sb_drained", sb.size(), 0);
`ifdef QUEUE_ALARM_EN
        check("alarm_count", n_alarm, ea);
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "timeout");
    end
endmodule
